// File: rtl/zed_btn_pkg.sv
// Shared types, default timing constants and sizing helper for the ZedBoard button conditioner.
// Long-press support is selected in the channel by the ZED_BTN_LONG_PRESS_EN macro.
package zed_btn_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_DEBOUNCE_DEFAULT = 1_000_000;
    localparam int BTN_LONG_DEFAULT     = 50_000_000;

    function automatic int cnt_width(input int max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/zed_btn_channel.sv
// One button channel: 2-flop synchronizer, debounce FSM and registered pulse outputs.
// Optional long-press counter is built only when ZED_BTN_LONG_PRESS_EN is defined.
module zed_btn_channel
    import zed_btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
    parameter int LONG_PRESS_CYCLES = BTN_LONG_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press,
    output logic release_pulse,
    output logic long_pulse
);

    localparam int            CW        = cnt_width(LONG_PRESS_CYCLES);
    localparam logic [CW-1:0] DEB_LIMIT = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]    sync_q;
    logic          sync;
    btn_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          level_n, press_n, release_n;

    assign sync = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            level         <= level_n;
            press         <= press_n;
            release_pulse <= release_n;
        end
    end

    // Any reversal of sync while waiting aborts the wait silently.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        level_n   = level;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            IDLE: begin
                if (sync) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!sync) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LIMIT) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                    level_n = 1'b1;
                    press_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (sync) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == DEB_LIMIT) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

`ifdef ZED_BTN_LONG_PRESS_EN
    localparam logic [CW-1:0] LONG_LIMIT = CW'(LONG_PRESS_CYCLES);
    localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_PRESS_CYCLES - 1);

    logic [CW-1:0] lcnt, lcnt_n;
    logic          long_n;

    // Counts only while steadily pressed; leaving PRESSED for any reason clears it.
    always_comb begin
        lcnt_n = '0;
        long_n = 1'b0;
        if (state == PRESSED && sync) begin
            lcnt_n = (lcnt == LONG_LIMIT) ? lcnt : lcnt + CNT_ONE;
            long_n = (lcnt == LONG_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lcnt       <= '0;
            long_pulse <= 1'b0;
        end else begin
            lcnt       <= lcnt_n;
            long_pulse <= long_n;
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/zed_button_conditioner.sv
// Debounces NUM_BTN raw push-buttons into clean levels and press/release/long strobes on GCLK.
// Long-press strobes exist only when ZED_BTN_LONG_PRESS_EN is defined; otherwise btn_long is 0.
module zed_button_conditioner
    import zed_btn_pkg::*;
#(
    parameter int NUM_BTN           = 4,
    parameter int DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEFAULT,
    parameter int LONG_PRESS_CYCLES = BTN_LONG_DEFAULT
) (
    input  logic               GCLK,
    input  logic               RST_N,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
        $error("LONG_PRESS_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        zed_btn_channel #(
            .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
        ) u_chan (
            .clk           (GCLK),
            .rst_n         (RST_N),
            .raw           (btn_raw[i]),
            .level         (btn_level[i]),
            .press         (btn_press[i]),
            .release_pulse (btn_release[i]),
            .long_pulse    (btn_long[i])
        );
    end

endmodule

// File: tb/tb_zed_button_conditioner.sv
// Bench for zed_button_conditioner: vector table, reset corner sequence, then random
// stimulus against a run-length reference model. Honours ZED_BTN_LONG_PRESS_EN.
module tb_zed_button_conditioner;

    localparam int N = 4;
    localparam int D = 4;
    localparam int L = 10;
`ifdef ZED_BTN_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic         GCLK = 1'b0;
    logic         RST_N;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

    int checks = 0;
    int errors = 0;

    zed_button_conditioner #(
        .NUM_BTN           (N),
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L)
    ) dut (
        .GCLK        (GCLK),
        .RST_N       (RST_N),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #10 GCLK = ~GCLK;

    typedef struct {
        bit       rst_n;
        logic [3:0] raw;
        int       reps;
        logic [3:0] lvl;
        logic [3:0] prs;
        logic [3:0] rel;
        logic [3:0] lng;
    } vec_t;

    vec_t vec_q[$];

    // Reference model: a channel flips its level once sync has disagreed with the
    // level for D+1 consecutive samples; sync is btn_raw delayed by two edges.
    logic [N-1:0] s1_m, s2_m, lvl_m, prs_m, rel_m, lng_m;
    int run_m[N];
    int age_m[N];

    task automatic model_step();
        logic su;
        int   prev_run;
        prs_m = '0;
        rel_m = '0;
        lng_m = '0;
        if (!RST_N) begin
            s1_m  = '0;
            s2_m  = '0;
            lvl_m = '0;
            for (int c = 0; c < N; c++) begin
                run_m[c] = 0;
                age_m[c] = 0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                su       = s2_m[c];
                prev_run = run_m[c];
                run_m[c] = (su != lvl_m[c]) ? run_m[c] + 1 : 0;
                if (LONG_EN && lvl_m[c]) begin
                    if (prev_run == 0 && su) begin
                        if (age_m[c] < L) begin
                            age_m[c]++;
                            if (age_m[c] == L) lng_m[c] = 1'b1;
                        end
                    end else begin
                        age_m[c] = 0;
                    end
                end
                if (run_m[c] == D + 1) begin
                    lvl_m[c] = ~lvl_m[c];
                    if (lvl_m[c]) prs_m[c] = 1'b1;
                    else          rel_m[c] = 1'b1;
                    run_m[c] = 0;
                    age_m[c] = 0;
                end
            end
            s2_m = s1_m;
            s1_m = btn_raw;
        end
    endtask

    // Advance past one active edge; inputs were set before, outputs are read after.
    task automatic tick();
        @(negedge GCLK);
        model_step();
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit r, input logic [3:0] raw, input int reps,
                       input logic [3:0] lvl, input logic [3:0] prs,
                       input logic [3:0] rel, input logic [3:0] lng);
        vec_q.push_back('{r, raw, reps, lvl, prs, rel, lng});
    endtask

    initial begin
        logic [3:0] long_exp;
        int         hold[N];
        int         rst_left;

        RST_N   = 1'b0;
        btn_raw = '0;
        tick();
        tick();

        long_exp = LONG_EN ? 4'h4 : 4'h0;
        // reset with all buttons held, then idle
        add(0, 4'hF, 3, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 4, 4'h0, 4'h0, 4'h0, 4'h0);
        // clean press and release on channel 0
        add(1, 4'h1, 6, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h1, 1, 4'h1, 4'h1, 4'h0, 4'h0);
        add(1, 4'h1, 5, 4'h1, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 6, 4'h1, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 4'h0, 4'h1, 4'h0);
        add(1, 4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0);
        // bouncing channel 1 never qualifies
        add(1, 4'h2, 3, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h2, 3, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 8, 4'h0, 4'h0, 4'h0, 4'h0);
        // channel 2 held 30 cycles: long pulse 10 cycles after level rises
        add(1, 4'h4, 6, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 1, 4'h4, 4'h4, 4'h0, 4'h0);
        add(1, 4'h4, 9, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 4'h4, 1, 4'h4, 4'h0, 4'h0, long_exp);
        add(1, 4'h4, 13, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 6, 4'h4, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 4'h0, 4'h4, 4'h0);
        add(1, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0);
        // simultaneous channels 0 and 3
        add(1, 4'h9, 6, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 4'h9, 1, 4'h9, 4'h9, 4'h0, 4'h0);
        add(1, 4'h9, 3, 4'h9, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 6, 4'h9, 4'h0, 4'h0, 4'h0);
        add(1, 4'h0, 1, 4'h0, 4'h0, 4'h9, 4'h0);
        add(1, 4'h0, 2, 4'h0, 4'h0, 4'h0, 4'h0);

        foreach (vec_q[i]) begin
            for (int r = 0; r < vec_q[i].reps; r++) begin
                RST_N   = vec_q[i].rst_n;
                btn_raw = vec_q[i].raw;
                tick();
                chk($sformatf("vec%0d.%0d level", i, r),   16'(btn_level),   16'(vec_q[i].lvl));
                chk($sformatf("vec%0d.%0d press", i, r),   16'(btn_press),   16'(vec_q[i].prs));
                chk($sformatf("vec%0d.%0d release", i, r), 16'(btn_release), 16'(vec_q[i].rel));
                chk($sformatf("vec%0d.%0d long", i, r),    16'(btn_long),    16'(vec_q[i].lng));
            end
        end

        // Reset during PRESS_WAIT on channel 3, button still held afterwards.
        RST_N   = 1'b1;
        btn_raw = 4'h8;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("pw%0d level", k), 16'(btn_level), 16'h0);
        end
        RST_N = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("inrst%0d outs", k),
                16'({btn_level, btn_press, btn_release, btn_long}), 16'h0);
        end
        // First edge after release samples the held button; level/press follow 2+D edges later.
        RST_N = 1'b1;
        for (int k = 0; k <= 7; k++) begin
            tick();
            chk($sformatf("held%0d level", k), 16'(btn_level), (k >= 6) ? 16'h8 : 16'h0);
            chk($sformatf("held%0d press", k), 16'(btn_press), (k == 6) ? 16'h8 : 16'h0);
        end
        btn_raw = 4'h0;
        for (int k = 0; k < 10; k++) tick();

        // Random stimulus with mixed short bounces, long holds and occasional resets.
        for (int c = 0; c < N; c++) hold[c] = $urandom_range(0, 6);
        rst_left = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (rst_left > 0) begin
                RST_N = 1'b0;
                rst_left--;
            end else if ($urandom_range(0, 399) == 0) begin
                RST_N    = 1'b0;
                rst_left = $urandom_range(0, 2);
            end else begin
                RST_N = 1'b1;
            end
            for (int c = 0; c < N; c++) begin
                if (hold[c] == 0) begin
                    btn_raw[c] = ~btn_raw[c];
                    hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(12, 30)
                                                          : $urandom_range(1, 8);
                end else begin
                    hold[c]--;
                end
            end
            tick();
            chk($sformatf("rand%0d", cyc),
                {btn_level, btn_press, btn_release, btn_long},
                {lvl_m, prs_m, rel_m, lng_m});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
